// File: rtl/ysyx_23060332_ctrl_if.sv
// ysyx_23060332_ctrl_if -- bundle of the control unit's pipeline-side signals.
//   IFU   : ifu_req_o, ifu_rvalid_i, ifu_rdata_i[31:0], pc_o[31:0]
//   IDU   : inst_o[31:0], dec_is_mem_i, dec_halt_i, reg_wen_i, reg_wen_o
//   EXU   : exu_jump_i, exu_jaddr_i[31:0]
//   LSU   : lsu_req_o, lsu_done_i
//   status: halt_o
// Modport master is the controller; modport slave is the surrounding core.
interface ysyx_23060332_ctrl_if;
  logic        ifu_req_o;
  logic        ifu_rvalid_i;
  logic [31:0] ifu_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        dec_is_mem_i;
  logic        dec_halt_i;
  logic        exu_jump_i;
  logic [31:0] exu_jaddr_i;
  logic        lsu_req_o;
  logic        lsu_done_i;
  logic        reg_wen_i;
  logic        reg_wen_o;
  logic        halt_o;

  modport master (
    output ifu_req_o, pc_o, inst_o, lsu_req_o, reg_wen_o, halt_o,
    input  ifu_rvalid_i, ifu_rdata_i, dec_is_mem_i, dec_halt_i,
           exu_jump_i, exu_jaddr_i, lsu_done_i, reg_wen_i
  );

  modport slave (
    input  ifu_req_o, pc_o, inst_o, lsu_req_o, reg_wen_o, halt_o,
    output ifu_rvalid_i, ifu_rdata_i, dec_is_mem_i, dec_halt_i,
           exu_jump_i, exu_jaddr_i, lsu_done_i, reg_wen_i
  );
endinterface

// File: rtl/ysyx_23060332_ctrl.sv
// ysyx_23060332_ctrl -- multi-cycle core sequencer
// (FETCH -> DECODE -> EXEC -> [MEM] -> WB, terminal HALT).
// Ports:
//   clk          core clock
//   rst          synchronous active-high reset
//   bus          ysyx_23060332_ctrl_if.master (IFU/IDU/EXU/LSU handshakes, pc, inst)
//   cycle_cnt_o  non-HALT cycle counter   (only with CTRL_PERF_EN)
//   inst_cnt_o   retired (WB) instruction counter (only with CTRL_PERF_EN)
// Optional feature macro: CTRL_PERF_EN enables the performance counters.
module ysyx_23060332_ctrl (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_23060332_ctrl_if.master       bus
`ifdef CTRL_PERF_EN
  ,
  output logic [31:0]                cycle_cnt_o,
  output logic [31:0]                inst_cnt_o
`endif
);

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        ifu_req;
  logic        lsu_req;
  logic        wb;
  logic        halt;
  logic [31:0] jump_tgt;

  // Jump targets are halfword-aligned by clearing bit 0.
  assign jump_tgt = bus.exu_jaddr_i & ~32'h1;

  // Request/status flags are registered alongside the state so they track the
  // state one-to-one; ifu_req is left low in the first post-reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      pc      <= 32'h8000_0000;
      inst    <= 32'h0000_0013;
      ifu_req <= 1'b0;
      lsu_req <= 1'b0;
      wb      <= 1'b0;
      halt    <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.ifu_rvalid_i) begin
            inst    <= bus.ifu_rdata_i;
            ifu_req <= 1'b0;
            state   <= DECODE;
          end else begin
            ifu_req <= 1'b1;
          end
        end
        DECODE: begin
          if (bus.dec_halt_i) begin
            halt  <= 1'b1;
            state <= HALT;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          if (bus.dec_is_mem_i) begin
            lsu_req <= 1'b1;
            state   <= MEM;
          end else begin
            wb    <= 1'b1;
            state <= WB;
          end
        end
        MEM: begin
          if (bus.lsu_done_i) begin
            lsu_req <= 1'b0;
            wb      <= 1'b1;
            state   <= WB;
          end
        end
        WB: begin
          pc      <= bus.exu_jump_i ? jump_tgt : pc + 32'd4;
          wb      <= 1'b0;
          ifu_req <= 1'b1;
          state   <= FETCH;
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          ifu_req <= 1'b0;
          lsu_req <= 1'b0;
          wb      <= 1'b0;
          state   <= FETCH;
        end
      endcase
    end
  end

`ifdef CTRL_PERF_EN
  logic [31:0] cycle_cnt;
  logic [31:0] inst_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else begin
      if (state != HALT) cycle_cnt <= cycle_cnt + 32'd1;
      if (state == WB)   inst_cnt  <= inst_cnt + 32'd1;
    end
  end

  assign cycle_cnt_o = cycle_cnt;
  assign inst_cnt_o  = inst_cnt;
`endif

  assign bus.ifu_req_o = ifu_req;
  assign bus.lsu_req_o = lsu_req;
  assign bus.pc_o      = pc;
  assign bus.inst_o    = inst;
  assign bus.halt_o    = halt;
  // reg_wen_i is only looked at while in WB.
  assign bus.reg_wen_o = wb & bus.reg_wen_i;

endmodule

// File: tb/tb_ysyx_23060332_ctrl.sv
// Self-checking bench for ysyx_23060332_ctrl. Each instruction is described by
// its handshake timing; the bench drives it cycle by cycle with random noise on
// every input the current phase must ignore, and checks outputs against the
// per-phase rules and an architectural pc/instruction/counter model.
module tb_ysyx_23060332_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_23060332_ctrl_if bus ();

`ifdef CTRL_PERF_EN
  logic [31:0] cycle_cnt;
  logic [31:0] inst_cnt;
  ysyx_23060332_ctrl dut (.clk(clk), .rst(rst), .bus(bus),
                          .cycle_cnt_o(cycle_cnt), .inst_cnt_o(inst_cnt));
`else
  ysyx_23060332_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_cyc;
  logic [31:0] m_icnt;
  bit          fresh;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    bus.ifu_rvalid_i = 1'($urandom % 2);
    bus.ifu_rdata_i  = $urandom;
    bus.dec_is_mem_i = 1'($urandom % 2);
    bus.dec_halt_i   = 1'($urandom % 2);
    bus.exu_jump_i   = 1'($urandom % 2);
    bus.exu_jaddr_i  = $urandom;
    bus.lsu_done_i   = 1'($urandom % 2);
    bus.reg_wen_i    = 1'($urandom % 2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    scramble();
    tick();
    rst    = 1'b0;
    m_pc   = 32'h8000_0000;
    m_inst = 32'h0000_0013;
    m_cyc  = '0;
    m_icnt = '0;
    fresh  = 1'b1;
  endtask

  // ctl vector = {ifu_req, lsu_req, reg_wen, halt}
  task automatic run_instr(input int fw, input bit halt, input bit mem, input int mc,
                           input bit jmp, input logic [31:0] ja, input bit wen,
                           input logic [31:0] data);
    logic [3:0] exp;
    logic [3:0] ctl;
    for (int k = 0; k <= fw; k++) begin
      scramble();
      bus.ifu_rvalid_i = (k == fw);
      if (k == fw) bus.ifu_rdata_i = data;
      #1;
      exp = {!(k == 0 && fresh), 3'b000};
      ctl = {bus.ifu_req_o, bus.lsu_req_o, bus.reg_wen_o, bus.halt_o};
      n_cmp++;
      if (ctl !== exp) begin
        n_err++; $display("FAIL fetch_ctl: got %b expected %b", ctl, exp);
      end
      n_cmp++;
      if (bus.pc_o !== m_pc) begin
        n_err++; $display("FAIL fetch_pc: got %h expected %h", bus.pc_o, m_pc);
      end
`ifdef CTRL_PERF_EN
      n_cmp++;
      if (cycle_cnt !== m_cyc || inst_cnt !== m_icnt) begin
        n_err++; $display("FAIL counters: got %0d/%0d expected %0d/%0d",
                          cycle_cnt, inst_cnt, m_cyc, m_icnt);
      end
`endif
      fresh = 1'b0;
      tick();
      m_cyc++;
    end
    m_inst = data;

    scramble();
    bus.dec_halt_i = halt;
    #1;
    ctl = {bus.ifu_req_o, bus.lsu_req_o, bus.reg_wen_o, bus.halt_o};
    n_cmp++;
    if (ctl !== 4'b0000) begin
      n_err++; $display("FAIL decode_ctl: got %b expected 0000", ctl);
    end
    n_cmp++;
    if (bus.inst_o !== m_inst) begin
      n_err++; $display("FAIL inst_latch: got %h expected %h", bus.inst_o, m_inst);
    end
    tick();
    m_cyc++;

    if (halt) begin
      for (int h = 0; h < 4; h++) begin
        scramble();
        #1;
        ctl = {bus.ifu_req_o, bus.lsu_req_o, bus.reg_wen_o, bus.halt_o};
        n_cmp++;
        if (ctl !== 4'b0001) begin
          n_err++; $display("FAIL halt_ctl: got %b expected 0001", ctl);
        end
        n_cmp++;
        if (bus.pc_o !== m_pc || bus.inst_o !== m_inst) begin
          n_err++; $display("FAIL halt_hold: got %h/%h expected %h/%h",
                            bus.pc_o, bus.inst_o, m_pc, m_inst);
        end
`ifdef CTRL_PERF_EN
        n_cmp++;
        if (cycle_cnt !== m_cyc || inst_cnt !== m_icnt) begin
          n_err++; $display("FAIL halt_counters: got %0d/%0d expected %0d/%0d",
                            cycle_cnt, inst_cnt, m_cyc, m_icnt);
        end
`endif
        tick();
      end
      return;
    end

    scramble();
    bus.dec_is_mem_i = mem;
    #1;
    ctl = {bus.ifu_req_o, bus.lsu_req_o, bus.reg_wen_o, bus.halt_o};
    n_cmp++;
    if (ctl !== 4'b0000) begin
      n_err++; $display("FAIL exec_ctl: got %b expected 0000", ctl);
    end
    tick();
    m_cyc++;

    if (mem) begin
      for (int j = 0; j < mc; j++) begin
        scramble();
        bus.lsu_done_i = (j == mc - 1);
        #1;
        ctl = {bus.ifu_req_o, bus.lsu_req_o, bus.reg_wen_o, bus.halt_o};
        n_cmp++;
        if (ctl !== 4'b0100) begin
          n_err++; $display("FAIL mem_ctl: cycle %0d got %b expected 0100", j, ctl);
        end
        n_cmp++;
        if (bus.inst_o !== m_inst || bus.pc_o !== m_pc) begin
          n_err++; $display("FAIL mem_hold: got %h/%h expected %h/%h",
                            bus.inst_o, bus.pc_o, m_inst, m_pc);
        end
        tick();
        m_cyc++;
      end
    end

    scramble();
    bus.reg_wen_i   = wen;
    bus.exu_jump_i  = jmp;
    bus.exu_jaddr_i = ja;
    #1;
    ctl = {bus.ifu_req_o, bus.lsu_req_o, bus.reg_wen_o, bus.halt_o};
    exp = {2'b00, wen, 1'b0};
    n_cmp++;
    if (ctl !== exp) begin
      n_err++; $display("FAIL wb_ctl: got %b expected %b", ctl, exp);
    end
    tick();
    m_cyc++;
    m_icnt++;
    m_pc = jmp ? {ja[31:1], 1'b0} : m_pc + 32'd4;
    n_cmp++;
    if (bus.pc_o !== m_pc) begin
      n_err++; $display("FAIL pc_next: got %h expected %h", bus.pc_o, m_pc);
    end
  endtask

  task automatic test_reset();
    do_reset();
    scramble();
    #1;
    n_cmp++;
    if ({bus.ifu_req_o, bus.lsu_req_o, bus.reg_wen_o, bus.halt_o} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ctl: got %b expected 0000",
                        {bus.ifu_req_o, bus.lsu_req_o, bus.reg_wen_o, bus.halt_o});
    end
    n_cmp++;
    if (bus.pc_o !== 32'h8000_0000 || bus.inst_o !== 32'h0000_0013) begin
      n_err++; $display("FAIL reset_regs: got %h/%h expected 80000000/00000013",
                        bus.pc_o, bus.inst_o);
    end
  endtask

  task automatic test_addi();
    run_instr(0, 1'b0, 1'b0, 0, 1'b0, 32'h0, 1'b1, 32'h0010_0093);
    n_cmp++;
    if (bus.pc_o !== 32'h8000_0004) begin
      n_err++; $display("FAIL addi_pc: got %h expected 80000004", bus.pc_o);
    end
  endtask

  task automatic test_load();
    do_reset();
    run_instr(0, 1'b0, 1'b1, 3, 1'b0, 32'h0, 1'b1, 32'h0000_2103);
`ifdef CTRL_PERF_EN
    n_cmp++;
    if (inst_cnt !== 32'd1 || cycle_cnt !== 32'd7) begin
      n_err++; $display("FAIL load_counters: got %0d/%0d expected 1/7", inst_cnt, cycle_cnt);
    end
`endif
  endtask

  task automatic test_jalr();
    run_instr(1, 1'b0, 1'b0, 0, 1'b1, 32'h8000_0101, 1'b1, 32'h0000_80e7);
    n_cmp++;
    if (bus.pc_o !== 32'h8000_0100) begin
      n_err++; $display("FAIL jalr_pc: got %h expected 80000100", bus.pc_o);
    end
  endtask

  task automatic test_wrap();
    run_instr(0, 1'b0, 1'b0, 0, 1'b1, 32'hFFFF_FFFD, 1'b0, 32'h0000_0067);
    run_instr(0, 1'b0, 1'b0, 0, 1'b0, 32'h0, 1'b1, 32'h0000_0013);
    n_cmp++;
    if (bus.pc_o !== 32'h0000_0000) begin
      n_err++; $display("FAIL wrap_pc: got %h expected 00000000", bus.pc_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_instr(int'($urandom % 3), 1'b0, 1'($urandom % 2), 1 + int'($urandom % 4),
                ($urandom % 4) == 0, $urandom, 1'($urandom % 2), $urandom);
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [31:0] d;
    d = $urandom;
    scramble(); bus.ifu_rvalid_i = 1'b1; bus.ifu_rdata_i = d; tick();
    scramble(); bus.dec_halt_i = 1'b0; tick();
    scramble(); bus.dec_is_mem_i = 1'b1; bus.ifu_rvalid_i = 1'b1; bus.ifu_rdata_i = ~d; tick();
    scramble(); bus.lsu_done_i = 1'b0;
    #1;
    n_cmp++;
    if (bus.lsu_req_o !== 1'b1 || bus.inst_o !== d) begin
      n_err++; $display("FAIL spurious_rvalid: got %b/%h expected 1/%h",
                        bus.lsu_req_o, bus.inst_o, d);
    end
    tick();
    do_reset();
    scramble();
    #1;
    n_cmp++;
    if ({bus.ifu_req_o, bus.lsu_req_o, bus.reg_wen_o, bus.halt_o} !== 4'b0000 ||
        bus.pc_o !== 32'h8000_0000 || bus.inst_o !== 32'h0000_0013) begin
      n_err++; $display("FAIL mem_reset: got %b %h %h expected 0000 80000000 00000013",
                        {bus.ifu_req_o, bus.lsu_req_o, bus.reg_wen_o, bus.halt_o},
                        bus.pc_o, bus.inst_o);
    end
    run_instr(2, 1'b0, 1'b0, 0, 1'b0, 32'h0, 1'b1, $urandom);
  endtask

  task automatic test_halt();
    run_instr(1, 1'b0, 1'b0, 0, 1'b0, 32'h0, 1'b1, $urandom);
    run_instr(0, 1'b1, 1'b0, 0, 1'b0, 32'h0, 1'b1, 32'h0010_0073);
  endtask

  task automatic test_reset_from_halt();
    do_reset();
    scramble();
    #1;
    n_cmp++;
    if (bus.halt_o !== 1'b0 || bus.pc_o !== 32'h8000_0000) begin
      n_err++; $display("FAIL halt_reset: got %b/%h expected 0/80000000", bus.halt_o, bus.pc_o);
    end
    test_addi();
  endtask

  initial begin
    scramble();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_addi();
    test_load();
    test_jalr();
    test_wrap();
    test_random();
    test_reset_mid_mem();
    test_halt();
    test_reset_from_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
